// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipeline writeback,
// MDU result stream, decode hazard query and the registered write port.
interface wb_port_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic        dec_we;
    logic [4:0]  dec_waddr;
    logic        dec_mdu;
    logic        stall_d;
    logic        bubble_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        output dec_rs, dec_rt, dec_we, dec_waddr, dec_mdu,
        input  mdu_ready, stall_d, bubble_req, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        input  dec_rs, dec_rt, dec_we, dec_waddr, dec_mdu,
        output mdu_ready, stall_d, bubble_req, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and a FIFO of MDU results, with a busy scoreboard and a starvation guard.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          r_rf_we;
    logic [4:0]    r_rf_waddr;
    logic [31:0]   r_rf_wdata;
    logic          r_src_mdu;
    logic [31:0]   r_busy;
    logic [3:0]    r_starve_cnt;
    logic          r_bubble_req;

    logic          w_pipe_claim;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_stall;
    logic          w_busy_set;
    logic [31:0]   w_busy_next;
    logic [3:0]    w_starve_next;
    logic          w_bubble_next;

    // A pipeline write to $0 is not a claim, so the MDU may use that cycle.
    assign w_pipe_claim = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    assign w_empty      = (r_count == '0);
    assign w_ready      = (r_count != FULL);
    assign w_push       = bus.mdu_valid && w_ready;
    assign w_pop        = !w_pipe_claim && !w_empty;
    assign w_stall      = r_busy[bus.dec_rs] | r_busy[bus.dec_rt]
                        | (bus.dec_we & r_busy[bus.dec_waddr]);
    assign w_busy_set   = bus.dec_mdu && bus.dec_we && (bus.dec_waddr != 5'd0) && !w_stall;

    assign bus.mdu_ready  = w_ready;
    assign bus.stall_d    = w_stall;
    assign bus.bubble_req = r_bubble_req;
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;

    // Next busy vector: clear after the MDU write cycle, set on MDU issue.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_we && r_src_mdu) begin
            w_busy_next[r_rf_waddr] = 1'b0;
        end else begin
            w_busy_next = w_busy_next;
        end
        if (w_busy_set) begin
            w_busy_next[bus.dec_waddr] = 1'b1;
        end else begin
            w_busy_next = w_busy_next;
        end
        w_busy_next[0] = 1'b0;
    end

    // Starvation counter and bubble request next state.
    always_comb begin
        w_starve_next = r_starve_cnt;
        w_bubble_next = r_bubble_req;
        if (w_pop) begin
            w_starve_next = 4'd0;
            w_bubble_next = 1'b0;
        end else if (!w_empty && w_pipe_claim && (r_starve_cnt != LIMIT)) begin
            w_starve_next = r_starve_cnt + 4'd1;
            w_bubble_next = r_bubble_req | (w_starve_next == LIMIT);
        end else begin
            w_bubble_next = r_bubble_req | (r_starve_cnt == LIMIT);
        end
    end

    // FIFO payload storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.mdu_waddr;
            r_fifo_data[r_wr_ptr] <= bus.mdu_wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write port selection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
            r_src_mdu  <= 1'b0;
        end else if (w_pipe_claim) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= bus.pipe_waddr;
            r_rf_wdata <= bus.pipe_wdata;
            r_src_mdu  <= 1'b0;
        end else if (w_pop) begin
            r_rf_we    <= (r_fifo_addr[r_rd_ptr] != 5'd0);
            r_rf_waddr <= r_fifo_addr[r_rd_ptr];
            r_rf_wdata <= r_fifo_data[r_rd_ptr];
            r_src_mdu  <= 1'b1;
        end else begin
            r_rf_we    <= 1'b0;
            r_src_mdu  <= 1'b0;
        end
    end

    // Scoreboard and starvation guard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= 32'd0;
            r_starve_cnt <= 4'd0;
            r_bubble_req <= 1'b0;
        end else begin
            r_busy       <= w_busy_next;
            r_starve_cnt <= w_starve_next;
            r_bubble_req <= w_bubble_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: expected register-file writes go into a scoreboard queue,
// a negedge monitor pops and compares every rf_we; status outputs checked inline.
module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [36:0] sb_q [$];

    wb_port_arbiter_if bus_if ();

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.pipe_we    = 1'b0;
        bus_if.pipe_waddr = 5'd0;
        bus_if.pipe_wdata = 32'd0;
        bus_if.mdu_valid  = 1'b0;
        bus_if.mdu_waddr  = 5'd0;
        bus_if.mdu_wdata  = 32'd0;
        bus_if.dec_rs     = 5'd0;
        bus_if.dec_rt     = 5'd0;
        bus_if.dec_we     = 1'b0;
        bus_if.dec_waddr  = 5'd0;
        bus_if.dec_mdu    = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d, input bit expect_wr);
        bus_if.pipe_we    = 1'b1;
        bus_if.pipe_waddr = a;
        bus_if.pipe_wdata = d;
        if (expect_wr) sb_q.push_back({a, d});
    endtask

    task automatic mdu(input logic [4:0] a, input logic [31:0] d);
        bus_if.mdu_valid = 1'b1;
        bus_if.mdu_waddr = a;
        bus_if.mdu_wdata = d;
    endtask

    // Scoreboard monitor: every register-file write must match the queue head.
    always @(negedge clk) begin
        logic [36:0] exp_w;
        if (rst && bus_if.rf_we) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got write r%0d=%h expected none",
                         bus_if.rf_waddr, bus_if.rf_wdata);
            end else begin
                exp_w = sb_q.pop_front();
                if ({bus_if.rf_waddr, bus_if.rf_wdata} !== exp_w) begin
                    n_err++;
                    $display("FAIL sb_write: got r%0d=%h expected r%0d=%h",
                             bus_if.rf_waddr, bus_if.rf_wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we",      {31'd0, bus_if.rf_we},      32'd0);
        check("rst_rf_waddr",   {27'd0, bus_if.rf_waddr},   32'd0);
        check("rst_rf_wdata",   bus_if.rf_wdata,            32'd0);
        check("rst_bubble",     {31'd0, bus_if.bubble_req}, 32'd0);
        check("rst_mdu_ready",  {31'd0, bus_if.mdu_ready},  32'd1);
        check("rst_stall",      {31'd0, bus_if.stall_d},    32'd0);
        rst = 1'b1;
        tick();

        // Pipeline only: one-cycle latency, and a $0 write never reaches the port.
        pipe(5'd5, 32'hDEADBEEF, 1'b1);
        tick();
        idle();
        check("pipe_rf_we",    {31'd0, bus_if.rf_we},    32'd1);
        check("pipe_rf_waddr", {27'd0, bus_if.rf_waddr}, 32'd5);
        check("pipe_rf_wdata", bus_if.rf_wdata,          32'hDEADBEEF);
        pipe(5'd0, 32'h00000055, 1'b0);
        tick();
        idle();
        check("pipe_r0_we", {31'd0, bus_if.rf_we}, 32'd0);
        tick();

        // MDU alone: busy set on issue, cleared after the write cycle.
        bus_if.dec_mdu = 1'b1; bus_if.dec_we = 1'b1; bus_if.dec_waddr = 5'd8;
        tick();
        idle();
        bus_if.dec_rs = 5'd8;
        #1;
        check("mdu_busy_stall", {31'd0, bus_if.stall_d}, 32'd1);
        mdu(5'd8, 32'h00001234);
        sb_q.push_back({5'd8, 32'h00001234});
        tick();
        bus_if.mdu_valid = 1'b0;
        check("mdu_n1_rf_we", {31'd0, bus_if.rf_we}, 32'd0);
        tick();
        check("mdu_n2_rf_we", {31'd0, bus_if.rf_we},   32'd1);
        check("mdu_n2_stall", {31'd0, bus_if.stall_d}, 32'd1);
        tick();
        check("mdu_n3_stall", {31'd0, bus_if.stall_d}, 32'd0);
        idle();
        tick();

        // WAW: a stalled MDU issue must not set a new busy bit.
        bus_if.dec_mdu = 1'b1; bus_if.dec_we = 1'b1; bus_if.dec_waddr = 5'd9;
        tick();
        #1;
        check("waw_stall", {31'd0, bus_if.stall_d}, 32'd1);
        bus_if.dec_waddr = 5'd10;
        bus_if.dec_rs    = 5'd9;
        #1;
        check("raw_stall", {31'd0, bus_if.stall_d}, 32'd1);
        tick();
        idle();
        bus_if.dec_rs = 5'd10;
        #1;
        check("waw_no_set", {31'd0, bus_if.stall_d}, 32'd0);
        mdu(5'd9, 32'h00000099);
        sb_q.push_back({5'd9, 32'h00000099});
        tick();
        bus_if.mdu_valid = 1'b0;
        repeat (3) tick();
        bus_if.dec_rs = 5'd9;
        #1;
        check("r9_released", {31'd0, bus_if.stall_d}, 32'd0);
        idle();
        tick();

        // Contention: continuous pipeline writes starve two queued MDU results.
        for (int k = 0; k < 10; k++) begin
            if (k == 2) check("cont_full",   {31'd0, bus_if.mdu_ready},  32'd0);
            if (k == 4) check("cont_bub_lo", {31'd0, bus_if.bubble_req}, 32'd0);
            if (k == 5) check("cont_bub_hi", {31'd0, bus_if.bubble_req}, 32'd1);
            if (k == 6) check("cont_bub_ig", {31'd0, bus_if.bubble_req}, 32'd1);
            if (k == 7) check("cont_bub_cl", {31'd0, bus_if.bubble_req}, 32'd0);
            if (k == 8) check("cont_ready",  {31'd0, bus_if.mdu_ready},  32'd1);
            idle();
            if (k == 0) mdu(5'd3, 32'h00000033);
            if (k == 1) mdu(5'd4, 32'h00000044);
            if (k == 6) mdu(5'd7, 32'h00000077);
            if (k <= 5 || k == 7) pipe(5'(20 + k), 32'hA0000000 + 32'(k), 1'b1);
            if (k == 6) sb_q.push_back({5'd3, 32'h00000033});
            if (k == 8) sb_q.push_back({5'd4, 32'h00000044});
            tick();
        end
        idle();
        tick();

        // FIFO wrap: six back-to-back results, then a discarded $0 entry.
        for (int k = 0; k < 6; k++) begin
            check("wrap_ready", {31'd0, bus_if.mdu_ready}, 32'd1);
            mdu(5'(11 + k), 32'hB0000000 + 32'(k));
            sb_q.push_back({5'(11 + k), 32'hB0000000 + 32'(k)});
            tick();
        end
        mdu(5'd0, 32'h0000DEAD);
        tick();
        mdu(5'd12, 32'h00000C12);
        sb_q.push_back({5'd12, 32'h00000C12});
        tick();
        idle();
        check("r0_pop_we", {31'd0, bus_if.rf_we}, 32'd0);
        repeat (3) tick();

        // Async reset with two queued entries and a pending busy bit.
        bus_if.dec_mdu = 1'b1; bus_if.dec_we = 1'b1; bus_if.dec_waddr = 5'd3;
        tick();
        idle();
        pipe(5'd21, 32'h00000061, 1'b1);
        mdu(5'd3, 32'h00000333);
        tick();
        idle();
        pipe(5'd22, 32'h00000062, 1'b1);
        mdu(5'd5, 32'h00000555);
        tick();
        idle();
        pipe(5'd23, 32'h00000063, 1'b0);
        bus_if.dec_rs = 5'd3;
        #1;
        check("pre_rst_stall", {31'd0, bus_if.stall_d},   32'd1);
        check("pre_rst_full",  {31'd0, bus_if.mdu_ready}, 32'd0);
        #4;
        rst = 1'b0;
        #1;
        check("arst_rf_we",  {31'd0, bus_if.rf_we},     32'd0);
        check("arst_ready",  {31'd0, bus_if.mdu_ready}, 32'd1);
        check("arst_stall",  {31'd0, bus_if.stall_d},   32'd0);
        idle();
        bus_if.dec_rs = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) tick();
        check("post_rst_stall", {31'd0, bus_if.stall_d}, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Pipeline writes always win. MDU results are buffered in a small FIFO and drained into free port cycles. A 32-entry busy scoreboard stalls decode against registers still owed by the MDU. A starvation guard requests a pipeline bubble when MDU results wait too long.

## Interface
Parameters:
- DEPTH, 2: MDU result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive blocked cycles before a bubble is requested (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pipe_we  in  1  pipeline writeback write request.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline result.
- mdu_valid  in  1  MDU result valid.
- mdu_waddr  in  5  MDU destination register.
- mdu_wdata  in  32  MDU result.
- mdu_ready  out  1  FIFO can accept; equals (count != DEPTH).
- dec_rs, dec_rt  in  5 each  decode-stage source registers.
- dec_we  in  1  decode instruction writes a register.
- dec_waddr  in  5  decode destination register.
- dec_mdu  in  1  decode instruction is an MDU op.
- stall_d  out  1  combinational decode stall.
- bubble_req  out  1  registered request for the pipeline to insert one writeback bubble.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  5  registered write address.
- rf_wdata  out  32  registered write data.

## Operation
- Port claim: the pipeline claims the port when pipe_we=1 and pipe_waddr≠0. Otherwise the port is free.
- Selection, each cycle:
  - Pipeline claims → load {1, pipe_waddr, pipe_wdata} into the rf_* registers; src_mdu=0.
  - Port free and FIFO non-empty → pop the head into the rf_* registers; src_mdu=1.
  - Otherwise → rf_we=0.
- Writes to $0 are discarded by either source:
  - A pipeline write to $0 frees the port.
  - An MDU entry for $0 is popped with rf_we=0.
- FIFO:
  - Push on mdu_valid && mdu_ready.
  - Pop on selection.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- Scoreboard busy[31:0]:
  - Set bit dec_waddr when dec_mdu && dec_we && dec_waddr≠0 && !stall_d.
  - Clear bit rf_waddr at the end of a cycle in which rf_we && src_mdu. This keeps busy high through the write cycle, so no regfile write-through is needed.
  - busy[0] is always 0.
  - A set and a clear of the same bit cannot coincide: WAW is stalled.
- stall_d = busy[dec_rs] | busy[dec_rt] | (dec_we & busy[dec_waddr]). It uses only the registered busy vector.
- Starvation guard:
  - starve_cnt increments each cycle the FIFO is non-empty and the pipeline claims the port. It saturates at STARVE_LIMIT.
  - starve_cnt resets to 0 on any FIFO pop.
  - bubble_req is set at the edge where starve_cnt reaches STARVE_LIMIT. It clears at the edge of the next FIFO pop.
  - If the pipeline ignores bubble_req, the pipeline still wins and bubble_req stays high.

## Timing
- Reset (rst=0, async) values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, bubble_req=0.
  - busy=0, FIFO empty, starve_cnt=0, src_mdu=0.
  - mdu_ready=1 and stall_d=0 while in reset.
  - Reset mid-operation discards all FIFO contents and pending busy bits.
- Pipeline latency: request in cycle N → rf_we=1 in cycle N+1.
- MDU latency, unobstructed: push at the end of cycle N → pop in N+1 → rf_we=1 in N+2 → busy cleared at the end of N+2 → stall_d low in N+3.
- mdu_ready is derived from registered count, so a full FIFO refuses a push even when a pop happens the same cycle.
- A pipeline claim on every cycle holds MDU entries indefinitely. The only release is via bubble_req, which rises STARVE_LIMIT cycles after blocking begins.

## Test plan
- Pipeline only: pipe_we=1, waddr=5, wdata=0xDEADBEEF in cycle 1 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 2. pipe_waddr=0 → rf_we stays 0.
- MDU alone:
  - Decode issues dec_mdu to r8 → busy[8]=1; dec_rs=8 gives stall_d=1.
  - mdu_valid with r8, 0x1234 → rf_we in 2 cycles.
  - stall_d drops the cycle after rf_we.
- Contention: pipeline writes every cycle while two MDU results (r3, r4) push; DEPTH=2.
  - mdu_ready=0 after two pushes.
  - bubble_req=1 after 4 blocked cycles.
  - Pipeline idles one cycle → r3 written; bubble_req clears; r4 follows on the next free cycle.
- WAW/hazard: with busy[9]=1, dec_we=1 and dec_waddr=9 → stall_d=1, and no new busy set occurs.
- FIFO wrap: 6 MDU results with idle pipeline, back-to-back → written in order, one per cycle; mdu_ready never drops.
- Async reset with 2 FIFO entries and busy[3]=1 → rf_we=0 immediately, mdu_ready=1, busy=0. After release, no stale write appears.
